// File: rtl/z80_cycle_tracker_pkg.sv
// ============================================================================
// Module   : z80_cycle_tracker_pkg
// Brief    : Shared Z80 bus definitions for the RAM-expansion front end:
//            cycle-type codes and default tracker configuration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package z80_cycle_tracker_pkg;

  // Bus-cycle classification codes, also used directly as FSM state encoding
  localparam logic [2:0] CYC_IDLE  = 3'd0;
  localparam logic [2:0] CYC_FETCH = 3'd1;
  localparam logic [2:0] CYC_MRD   = 3'd2;
  localparam logic [2:0] CYC_MWR   = 3'd3;
  localparam logic [2:0] CYC_RFSH  = 3'd4;
  localparam logic [2:0] CYC_IO    = 3'd5;
  localparam logic [2:0] CYC_INTA  = 3'd6;

  // Default tag in data[7:6] marking a bank-register write
  localparam logic [1:0] REG_TAG_DEF = 2'b11;

  // Default T-state counter width
  localparam int TCNT_W_DEF = 3;

endpackage : z80_cycle_tracker_pkg

`default_nettype wire

// File: rtl/z80_edge_det.sv
// ============================================================================
// Module   : z80_edge_det
// Brief    : Falling-edge detector for an active-low Z80 strobe. The history
//            flop resets to DISARM_VAL; with the default of 0 no edge can be
//            reported until the strobe has been sampled high at least once.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_edge_det #(
  parameter logic DISARM_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_b,
  input  logic sig_b,
  output logic sig_q,
  output logic fall
);

  logic r_q;

  // Previous-sample history of the strobe, updated every clock
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_q <= DISARM_VAL;
    end else begin
      r_q <= sig_b;
    end
  end

  assign sig_q = r_q;
  assign fall  = r_q & ~sig_b;

endmodule : z80_edge_det

`default_nettype wire

// File: rtl/z80_cycle_tracker.sv
// ============================================================================
// Module   : z80_cycle_tracker
// Brief    : Classifies Z80 bus cycles (fetch, mem read/write, refresh, IO,
//            interrupt ack), counts T-states, predicts memory writes and
//            captures bank-select IO writes as a one-clock strobe.
// Options  : IOWR_GLITCH_FILTER_EN - require the bank-write condition on two
//            consecutive clocks before strobing (data from second sample).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_cycle_tracker
  import z80_cycle_tracker_pkg::*;
#(
  parameter int         TCNT_W  = TCNT_W_DEF,
  parameter logic [1:0] REG_TAG = REG_TAG_DEF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              mreq_b,
  input  logic              iorq_b,
  input  logic              rd_b,
  input  logic              wr_b,
  input  logic              m1_b,
  input  logic              rfsh_b,
  input  logic              adr15,
  input  logic              adr14,
  input  logic              adr8,
  input  logic [7:0]        data,
  output logic [2:0]        cyc_type,
  output logic              mwr_cyc,
  output logic              mwr_cyc_d,
  output logic              adr15_lat,
  output logic [TCNT_W-1:0] tcount,
  output logic              reg_wr_stb,
  output logic [5:0]        reg_data,
  output logic              reg_port
);

  localparam logic [TCNT_W-1:0] TC_MAX = {TCNT_W{1'b1}};
  localparam logic [TCNT_W-1:0] TC_ONE = {{(TCNT_W-1){1'b0}}, 1'b1};

  logic              w_mreq_q, w_mreq_fall;
  logic              w_iorq_q, w_iorq_fall;
  logic [2:0]        r_state, w_next;
  logic              w_enter;
  logic              r_mwr;
  logic              r_a15;
  logic [TCNT_W-1:0] r_tcount;
  logic              r_taken;
  logic              w_qual, w_fire;
  logic              r_stb;
  logic [5:0]        r_rdata;
  logic              r_rport;
  logic              w_unused;

  z80_edge_det #(.DISARM_VAL(1'b0)) u_mreq_edge (
    .clk     (clk),
    .reset_b (reset_b),
    .sig_b   (mreq_b),
    .sig_q   (w_mreq_q),
    .fall    (w_mreq_fall)
  );

  z80_edge_det #(.DISARM_VAL(1'b0)) u_iorq_edge (
    .clk     (clk),
    .reset_b (reset_b),
    .sig_b   (iorq_b),
    .sig_q   (w_iorq_q),
    .fall    (w_iorq_fall)
  );

  // Next-state: a fresh strobe edge always starts a new cycle (MREQ before
  // IORQ), so back-to-back cycles never need to pass through IDLE
  always_comb begin
    w_next = r_state;
    if (w_mreq_fall) begin
      if (!rfsh_b)     w_next = CYC_RFSH;
      else if (!m1_b)  w_next = CYC_FETCH;
      else if (!rd_b)  w_next = CYC_MRD;
      else             w_next = CYC_MWR;
    end else if (w_iorq_fall) begin
      w_next = m1_b ? CYC_IO : CYC_INTA;
    end else if (r_state == CYC_FETCH && !rfsh_b) begin
      w_next = CYC_RFSH;
    end else if (r_state != CYC_IDLE && mreq_b && iorq_b) begin
      w_next = CYC_IDLE;
    end
  end

  // Entering a new cycle: state change or re-trigger by a new edge
  assign w_enter = (w_next != CYC_IDLE) &&
                   ((w_next != r_state) || w_mreq_fall || w_iorq_fall);

  // Cycle state, registered write flag and T-state counter
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state  <= CYC_IDLE;
      r_mwr    <= 1'b0;
      r_tcount <= '0;
    end else begin
      r_state <= w_next;
      r_mwr   <= (w_next == CYC_MWR);
      if (w_enter || w_next == CYC_IDLE) begin
        r_tcount <= '0;
      end else if (r_tcount != TC_MAX) begin
        r_tcount <= r_tcount + TC_ONE;
      end
    end
  end

  // Address bit 15 snapshot at the start of each memory cycle
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_a15 <= 1'b0;
    end else if (w_mreq_fall) begin
      r_a15 <= adr15;
    end
  end

  // Bank-register write qualifier; r_taken limits it to once per IO cycle
  assign w_qual = (r_state == CYC_IO) && !wr_b && !adr15 &&
                  (data[7:6] == REG_TAG) && !r_taken;

`ifdef IOWR_GLITCH_FILTER_EN
  logic r_pend;

  // Remember a qualifying sample so the strobe needs two in a row
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_qual;
    end
  end

  assign w_fire = w_qual && r_pend;
`else
  assign w_fire = w_qual;
`endif

  // Strobe, payload capture and per-cycle taken flag
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_stb   <= 1'b0;
      r_rdata <= '0;
      r_rport <= 1'b0;
      r_taken <= 1'b0;
    end else begin
      r_stb <= w_fire;
      if (w_fire) begin
        r_rdata <= data[5:0];
        r_rport <= adr8;
      end
      if (r_state == CYC_IDLE || w_enter) begin
        r_taken <= 1'b0;
      end else if (w_fire) begin
        r_taken <= 1'b1;
      end
    end
  end

  assign cyc_type   = r_state;
  assign mwr_cyc    = r_mwr;
  assign mwr_cyc_d  = w_mreq_q & ~mreq_b & rfsh_b & rd_b & m1_b;
  assign adr15_lat  = r_a15;
  assign tcount     = r_tcount;
  assign reg_wr_stb = r_stb;
  assign reg_data   = r_rdata;
  assign reg_port   = r_rport;

  // adr14 is part of the bus interface but not needed for classification
  assign w_unused = &{1'b0, adr14, w_iorq_q};

endmodule : z80_cycle_tracker

`default_nettype wire

// File: tb/tb_z80_cycle_tracker.sv
// ============================================================================
// Module   : tb_z80_cycle_tracker
// Brief    : Directed table-driven bench for z80_cycle_tracker, plus hand
//            sequences for IO capture, wait stretch and reset mid-cycle.
//            Honours IOWR_GLITCH_FILTER_EN for strobe latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z80_cycle_tracker;

`ifdef IOWR_GLITCH_FILTER_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_b;
  logic       mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b;
  logic       adr15, adr14, adr8;
  logic [7:0] data;
  logic [2:0] cyc_type;
  logic       mwr_cyc, mwr_cyc_d, adr15_lat;
  logic [2:0] tcount;
  logic       reg_wr_stb;
  logic [5:0] reg_data;
  logic       reg_port;

  always #5 clk = ~clk;

  z80_cycle_tracker dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .mreq_b     (mreq_b),
    .iorq_b     (iorq_b),
    .rd_b       (rd_b),
    .wr_b       (wr_b),
    .m1_b       (m1_b),
    .rfsh_b     (rfsh_b),
    .adr15      (adr15),
    .adr14      (adr14),
    .adr8       (adr8),
    .data       (data),
    .cyc_type   (cyc_type),
    .mwr_cyc    (mwr_cyc),
    .mwr_cyc_d  (mwr_cyc_d),
    .adr15_lat  (adr15_lat),
    .tcount     (tcount),
    .reg_wr_stb (reg_wr_stb),
    .reg_data   (reg_data),
    .reg_port   (reg_port)
  );

  typedef struct {
    logic       mq, iq, rd, wr, m1, rf, a15, a8;
    logic [7:0] d;
    logic       e_mwrd;
    logic [2:0] e_cyc;
    logic [2:0] e_tc;
    logic       e_stb;
    logic       e_a15l;
  } row_t;

  row_t       tbl[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [5:0] e_rdata = '0;
  logic       e_rport = 1'b0;
  logic       e_a15l  = 1'b0;

  function automatic row_t mk(input logic mq, iq, rd, wr, m1, rf, a15, a8,
                              input logic [7:0] d, input logic mwrd,
                              input logic [2:0] cyc, input logic [2:0] tc,
                              input logic stb, input logic a15l);
    row_t r;
    r.mq = mq; r.iq = iq; r.rd = rd; r.wr = wr; r.m1 = m1; r.rf = rf;
    r.a15 = a15; r.a8 = a8; r.d = d;
    r.e_mwrd = mwrd; r.e_cyc = cyc; r.e_tc = tc; r.e_stb = stb; r.e_a15l = a15l;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one clock of inputs: combinational check before the edge,
  // registered checks just after it
  task automatic run_row(input row_t r, input string tag);
    mreq_b = r.mq; iorq_b = r.iq; rd_b = r.rd; wr_b = r.wr;
    m1_b = r.m1; rfsh_b = r.rf; adr15 = r.a15; adr8 = r.a8; data = r.d;
    #1;
    chk({tag, " mwr_cyc_d"}, {7'd0, mwr_cyc_d}, {7'd0, r.e_mwrd});
    @(posedge clk); #1;
    chk({tag, " cyc_type"},   {5'd0, cyc_type},   {5'd0, r.e_cyc});
    chk({tag, " mwr_cyc"},    {7'd0, mwr_cyc},    {7'd0, (r.e_cyc == 3'd3)});
    chk({tag, " tcount"},     {5'd0, tcount},     {5'd0, r.e_tc});
    chk({tag, " reg_wr_stb"}, {7'd0, reg_wr_stb}, {7'd0, r.e_stb});
    chk({tag, " adr15_lat"},  {7'd0, adr15_lat},  {7'd0, r.e_a15l});
    chk({tag, " reg_data"},   {2'd0, reg_data},   {2'd0, e_rdata});
    chk({tag, " reg_port"},   {7'd0, reg_port},   {7'd0, e_rport});
    e_a15l = r.e_a15l;
  endtask

  // One IO cycle: entry clock, nq clocks with WR low, ntail with WR high
  task automatic io_seq(input logic a15, input logic a8, input logic [7:0] d,
                        input int nq, input int ntail);
    logic       qual;
    logic       stb;
    logic [2:0] tc;
    qual = (a15 == 1'b0) && (d[7:6] == 2'b11);
    run_row(mk(1, 0, 1, 1, 1, 1, a15, a8, d, 0, 3'd5, 3'd0, 0, e_a15l), "io_entry");
    for (int k = 0; k < nq + ntail; k++) begin
      stb = qual && (k == LAT) && (k < nq);
      if (stb) begin
        e_rdata = d[5:0];
        e_rport = a8;
      end
      tc = (k + 1 > 7) ? 3'd7 : 3'(k + 1);
      run_row(mk(1, 0, 1, (k < nq) ? 1'b0 : 1'b1, 1, 1, a15, a8, d,
                 0, 3'd5, tc, stb, e_a15l), "io");
    end
    run_row(mk(1, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, e_a15l), "io_exit");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset asserted while a memory read is in progress
    reset_b = 1'b0; mreq_b = 1'b0; iorq_b = 1'b1; rd_b = 1'b0; wr_b = 1'b1;
    m1_b = 1'b1; rfsh_b = 1'b1; adr15 = 1'b1; adr14 = 1'b0; adr8 = 1'b0;
    data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset cyc_type",   {5'd0, cyc_type},   8'd0);
    chk("reset mwr_cyc",    {7'd0, mwr_cyc},    8'd0);
    chk("reset mwr_cyc_d",  {7'd0, mwr_cyc_d},  8'd0);
    chk("reset tcount",     {5'd0, tcount},     8'd0);
    chk("reset reg_wr_stb", {7'd0, reg_wr_stb}, 8'd0);
    chk("reset reg_data",   {2'd0, reg_data},   8'd0);
    chk("reset reg_port",   {7'd0, reg_port},   8'd0);
    chk("reset adr15_lat",  {7'd0, adr15_lat},  8'd0);
    reset_b = 1'b1;

    //           mq iq rd wr m1 rf a15 a8 data    mwrd cyc   tc    stb a15l
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 0)); // disarmed
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0, 8'h00, 1, 3'd3, 3'd0, 0, 1)); // MWR
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, 0, 8'h00, 0, 3'd3, 3'd1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, 0, 8'h00, 0, 3'd3, 3'd2, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0, 8'h00, 0, 3'd2, 3'd0, 0, 0)); // MRD a15=0
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 8'h00, 0, 3'd1, 3'd0, 0, 1)); // FETCH
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 8'h00, 0, 3'd1, 3'd1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 1, 0, 8'h00, 0, 3'd4, 3'd0, 0, 1)); // ->RFSH
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 1, 0, 8'h00, 0, 3'd4, 3'd0, 0, 1)); // new MREQ
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 1, 0, 8'h00, 0, 3'd4, 3'd1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 0, 1, 0, 1, 8'hC5, 0, 3'd6, 3'd0, 0, 1)); // INTA
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 1, 8'hC5, 0, 3'd6, 3'd1, 0, 1)); // no capture
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 8'h00, 0, 3'd2, 3'd0, 0, 1)); // MREQ wins
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      run_row(tbl[i], $sformatf("vec%0d", i));
    end

    io_seq(1'b0, 1'b1, 8'hC5, 3, 1);  // bank write 0x7F00
    io_seq(1'b1, 1'b1, 8'hC5, 3, 0);  // port 0xFF00 ignored
    io_seq(1'b0, 1'b1, 8'h85, 3, 0);  // tag mismatch ignored
    io_seq(1'b0, 1'b0, 8'hDA, 11, 0); // wait stretch, 12 clocks in IO
    io_seq(1'b0, 1'b1, 8'hE3, 1, 2);  // single-clock write
    io_seq(1'b0, 1'b1, 8'hF1, 2, 1);  // two-clock write

    // Reset asynchronously in the middle of a memory write
    run_row(mk(0, 1, 1, 1, 1, 1, 1, 0, 8'h00, 1, 3'd3, 3'd0, 0, 1), "rst_pre");
    #1;
    reset_b = 1'b0;
    #1;
    e_rdata = '0; e_rport = 1'b0;
    chk("async cyc_type",  {5'd0, cyc_type},  8'd0);
    chk("async mwr_cyc",   {7'd0, mwr_cyc},   8'd0);
    chk("async adr15_lat", {7'd0, adr15_lat}, 8'd0);
    chk("async reg_data",  {2'd0, reg_data},  8'd0);
    @(posedge clk); #1;
    reset_b = 1'b1;
    run_row(mk(0, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 0), "rst_hold0");
    run_row(mk(0, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 0), "rst_hold1");
    run_row(mk(1, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 0), "rst_high");
    run_row(mk(0, 1, 0, 1, 1, 1, 1, 0, 8'h00, 0, 3'd2, 3'd0, 0, 1), "rst_mrd");
    run_row(mk(1, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 3'd0, 3'd0, 0, 1), "rst_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_z80_cycle_tracker

`default_nettype wire
